// File: rtl/ysyx_25030085_ifu.sv
// Instruction fetch: accepts a PC, issues one AR/R read, returns {inst, pc, err} to decode.
// Faults: 01 misaligned PC (no bus access), 10 bus error response, 11 response timeout.
module ysyx_25030085_ifu #(
  parameter logic [31:0] RESET_INST     = 32'h0000_0013,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [1:0]  inst_err,
  output logic        inst_valid,
  input  logic        inst_ready
);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN, S_OUT} state_t;

  localparam logic [1:0]  ERR_NONE     = 2'b00;
  localparam logic [1:0]  ERR_MISALIGN = 2'b01;
  localparam logic [1:0]  ERR_BUS      = 2'b10;
  localparam logic [1:0]  ERR_TIMEOUT  = 2'b11;
  localparam logic [15:0] TMO_LAST     = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic [31:0] r_araddr;
  logic [1:0]  r_inst_err;
  logic [15:0] r_cnt;
  logic        r_flush_pend;
  logic        w_pc_fire;
  logic        w_misalign;
  logic        w_timeout;

  assign w_pc_fire  = pc_valid & pc_ready;
  assign w_misalign = (pc_i[1:0] != 2'b00);
  assign w_timeout  = !rvalid && (r_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_pc_fire) w_next = w_misalign ? S_OUT : S_ADDR;
      S_ADDR:  if (arready) w_next = (r_flush_pend || flush) ? S_DRAIN : S_DATA;
      S_DATA: begin
        if (rvalid)         w_next = flush ? S_IDLE : S_OUT;
        // a timed-out bus is never drained, so a coinciding flush just returns to idle
        else if (w_timeout) w_next = flush ? S_IDLE : S_OUT;
        else if (flush)     w_next = S_DRAIN;
      end
      S_DRAIN: if (rvalid) w_next = S_IDLE;
      S_OUT:   if (flush || inst_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    pc_ready   = rst && (r_state == S_IDLE) && !flush;
    arvalid    = (r_state == S_ADDR);
    rready     = (r_state == S_DATA) || (r_state == S_DRAIN);
    inst_valid = (r_state == S_OUT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_inst       <= RESET_INST;
      r_inst_pc    <= 32'h0;
      r_inst_err   <= ERR_NONE;
      r_araddr     <= 32'h0;
      r_cnt        <= 16'h0;
      r_flush_pend <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_pc_fire) begin
          r_inst_pc    <= pc_i;
          r_flush_pend <= 1'b0;
          if (w_misalign) begin
            r_inst     <= RESET_INST;
            r_inst_err <= ERR_MISALIGN;
          end else begin
            r_araddr   <= pc_i;
          end
        end
        S_ADDR: begin
          // arvalid stays up after a flush; the response is drained instead
          if (flush)   r_flush_pend <= 1'b1;
          if (arready) r_cnt <= 16'h0;
        end
        S_DATA: begin
          if (rvalid) begin
            if (!flush) begin
              r_inst     <= rdata;
              r_inst_err <= (rresp != 2'b00) ? ERR_BUS : ERR_NONE;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
            if (w_timeout) begin
              r_inst     <= RESET_INST;
              r_inst_err <= ERR_TIMEOUT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign araddr   = r_araddr;
  assign inst     = r_inst;
  assign inst_pc  = r_inst_pc;
  assign inst_err = r_inst_err;
endmodule

// File: tb/tb_ysyx_25030085_ifu.sv
// Bench for ysyx_25030085_ifu: scripted fetches against a memory responder with programmable
// AR/R delays; expected {inst, pc, err} queued at PC acceptance and compared on delivery.
module tb_ysyx_25030085_ifu;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [1:0]  inst_err;
  logic        inst_valid;
  logic        inst_ready;

  always #5 clk = ~clk;

  ysyx_25030085_ifu #(.RESET_INST(32'h0000_0013), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err), .inst_valid(inst_valid),
    .inst_ready(inst_ready)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  err;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0093;
    return {a[15:0], 16'h0513} ^ 32'h0F0F_0000;
  endfunction

  // memory responder configuration (written by the main sequence only)
  int         m_ar_dly = 0;
  int         m_r_dly  = 0;
  logic [1:0] m_resp   = 2'b00;
  bit         m_never  = 1'b0;

  // memory responder: drives at +2 after each rising edge
  initial begin
    int acnt, rcnt;
    bit busy, q_arv, q_rrdy, q_rst, ar_fire, r_fire;
    logic [31:0] q_addr, r_addr;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    acnt = 0; rcnt = 0; busy = 0; q_arv = 0; q_rrdy = 0; q_rst = 0;
    q_addr = 32'h0; r_addr = 32'h0;
    forever begin
      @(posedge clk); #2;
      ar_fire = q_arv && arready;
      r_fire  = q_rrdy && rvalid;
      if (!q_rst) begin
        arready = 1'b0; rvalid = 1'b0; busy = 0; acnt = 0; rcnt = 0;
      end else begin
        if (r_fire) begin rvalid = 1'b0; busy = 0; end
        if (ar_fire) begin arready = 1'b0; busy = 1; acnt = 0; rcnt = 0; r_addr = q_addr; end
        if (busy && !rready) begin busy = 0; rvalid = 1'b0; end
        if (!busy && arvalid && !arready) begin
          if (acnt >= m_ar_dly) arready = 1'b1;
          else acnt++;
        end
        if (busy && !rvalid && !m_never) begin
          if (rcnt >= m_r_dly) begin
            rvalid = 1'b1; rdata = mem_word(r_addr); rresp = m_resp;
          end else rcnt++;
        end
      end
      q_arv = arvalid; q_rrdy = rready; q_addr = araddr; q_rst = rst;
    end
  end

  // monitor: samples on the falling edge
  int cyc = 0, t_acc = 0, acc_gap = 0, last_lat = 0;
  int iv_cnt = 0, ar_cnt = 0, rr_cnt = 0, deliveries = 0;
  initial begin
    bit p_arv, p_ardy, p_iv, p_ird, p_flush, p_rst;
    logic [31:0] p_addr, p_inst, p_ipc;
    logic [1:0]  p_ierr;
    exp_t e;
    p_arv = 0; p_ardy = 0; p_iv = 0; p_ird = 0; p_flush = 0; p_rst = 0;
    p_addr = 32'h0; p_inst = 32'h0; p_ipc = 32'h0; p_ierr = 2'b00;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst && pc_valid && pc_ready) begin acc_gap = cyc - t_acc; t_acc = cyc; end
      if (inst_valid === 1'b1 && !p_iv) last_lat = cyc - t_acc;
      if (inst_valid === 1'b1) iv_cnt++;
      if (arvalid === 1'b1) ar_cnt++;
      if (rready === 1'b1) rr_cnt++;
      if (p_rst && p_arv && !p_ardy)
        chk("ar_hold", 96'({arvalid, araddr}), 96'({1'b1, p_addr}));
      if (p_rst && p_iv && !p_ird && !p_flush)
        chk("out_hold", 96'({inst_valid, inst, inst_pc, inst_err}),
            96'({1'b1, p_inst, p_ipc, p_ierr}));
      if (rst && inst_valid === 1'b1 && inst_ready && !flush) begin
        deliveries++;
        if (sb.size() == 0) chk("sb_underflow", 96'(sb.size()), 96'(1));
        else begin
          e = sb.pop_front();
          chk("inst", 96'(inst), 96'(e.inst));
          chk("inst_pc", 96'(inst_pc), 96'(e.pc));
          chk("inst_err", 96'(inst_err), 96'(e.err));
        end
      end
      p_arv = arvalid; p_ardy = arready; p_addr = araddr;
      p_iv = inst_valid; p_ird = inst_ready; p_flush = flush; p_rst = rst;
      p_inst = inst; p_ipc = inst_pc; p_ierr = inst_err;
    end
  end

  task automatic fetch(input logic [31:0] a, input bit push);
    int n;
    exp_t e;
    n = 0;
    pc_i = a; pc_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!pc_ready && n < 64);
    chk("pc_accept", 96'(pc_ready), 96'(1));
    if (push) begin
      e.pc = a;
      if (a[1:0] != 2'b00)   begin e.inst = 32'h0000_0013; e.err = 2'b01; end
      else if (m_never)      begin e.inst = 32'h0000_0013; e.err = 2'b11; end
      else begin
        e.inst = mem_word(a);
        e.err  = (m_resp != 2'b00) ? 2'b10 : 2'b00;
      end
      sb.push_back(e);
    end
    @(posedge clk); #1;
    pc_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    bit done;
    n = 0; done = 0;
    while (!done && n < budget) begin
      @(negedge clk); n++;
      done = (sb.size() == 0) && pc_ready && !inst_valid && !arvalid && !rready;
    end
    chk(tag, 96'(done), 96'(1));
    @(posedge clk); #1;
  endtask

  // sel 0: wait for inst_valid, sel 1: wait for rready
  task automatic wait_for(input string tag, input int sel, input int budget);
    int n;
    bit seen;
    n = 0; seen = 0;
    while (!seen && n < budget) begin
      @(negedge clk); n++;
      seen = (sel == 0) ? inst_valid : rready;
    end
    chk(tag, 96'(seen), 96'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    int d0, a0, r0, i0;
    rst = 1'b0; pc_i = 32'h0; pc_valid = 1'b0; flush = 1'b0; inst_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_inst", 96'(inst), 96'(32'h0000_0013));
    chk("rst_inst_pc", 96'(inst_pc), 96'(0));
    chk("rst_inst_err", 96'(inst_err), 96'(0));
    chk("rst_araddr", 96'(araddr), 96'(0));
    chk("rst_handshakes", 96'({inst_valid, arvalid, rready, pc_ready}), 96'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pc_ready", 96'(pc_ready), 96'(1));
    @(posedge clk); #1;

    // normal and back-to-back fetches
    fetch(32'h8000_0000, 1'b1);
    fetch(32'h8000_0004, 1'b1);
    chk("lat_first", 96'(last_lat), 96'(3));
    chk("b2b_gap", 96'(acc_gap), 96'(4));
    wait_done("done_normal", 20);
    chk("lat_second", 96'(last_lat), 96'(3));

    // backpressure on all three handshakes
    d0 = deliveries;
    m_ar_dly = 3; m_r_dly = 2; inst_ready = 1'b0;
    fetch(32'h8000_0100, 1'b1);
    wait_for("bp_valid", 0, 40);
    repeat (5) @(posedge clk);
    #1 inst_ready = 1'b1;
    wait_done("done_bp", 20);
    chk("bp_count", 96'(deliveries - d0), 96'(1));
    m_ar_dly = 0; m_r_dly = 0;

    // misaligned PC never reaches the bus
    a0 = ar_cnt;
    fetch(32'h8000_0002, 1'b1);
    wait_done("done_mis", 20);
    chk("mis_no_ar", 96'(ar_cnt - a0), 96'(0));
    chk("mis_lat", 96'(last_lat), 96'(1));

    // bus error response
    m_resp = 2'b10;
    fetch(32'h8000_0010, 1'b1);
    wait_done("done_buserr", 20);
    m_resp = 2'b00;

    // response never arrives
    r0 = rr_cnt;
    m_never = 1'b1;
    fetch(32'h8000_0050, 1'b1);
    wait_done("done_tmo", 400);
    chk("tmo_cycles", 96'(rr_cnt - r0), 96'(255));
    m_never = 1'b0;

    // flush while the address is pending: response drained, nothing delivered
    i0 = iv_cnt; r0 = rr_cnt;
    m_ar_dly = 2; m_r_dly = 3;
    fetch(32'h8000_0020, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_done("done_flush_addr", 40);
    chk("flush_addr_no_valid", 96'(iv_cnt - i0), 96'(0));
    chk("flush_addr_drain", 96'(rr_cnt - r0), 96'(4));
    m_ar_dly = 0; m_r_dly = 0;

    // flush wins over inst_ready in OUT
    d0 = deliveries;
    inst_ready = 1'b0;
    fetch(32'h8000_0030, 1'b0);
    wait_for("flush_out_valid", 0, 20);
    flush = 1'b1; inst_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_out_pc_ready", 96'(pc_ready), 96'(1));
    chk("flush_out_valid_low", 96'(inst_valid), 96'(0));
    chk("flush_out_no_xfer", 96'(deliveries - d0), 96'(0));
    @(posedge clk); #1;

    // reset in the middle of a data phase
    m_never = 1'b1;
    fetch(32'h8000_0040, 1'b0);
    wait_for("rst_data_phase", 1, 20);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_inst", 96'(inst), 96'(32'h0000_0013));
    chk("rst_mid_outs", 96'({inst_valid, arvalid, rready}), 96'(0));
    chk("rst_mid_pc_ready", 96'(pc_ready), 96'(1));
    @(posedge clk); #1;
    m_never = 1'b0;
    fetch(32'h8000_0044, 1'b1);
    wait_done("done_after_rst", 20);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule
